// File: rtl/display_scheduler.sv
// display_scheduler: round-robin time-sharing of the 8-digit hex display
// between four requesters, with a fixed dwell per grant and an optional
// blanking gap whenever the shown source changes.
module display_scheduler #(
  parameter int DWELL = 100_000_000,
  parameter int GAP   = 1000,
  parameter int CW    = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [127:0] data_in,
  output logic [31:0]  num_out,
  output logic         power_on,
  output logic [3:0]   grant,
  output logic [1:0]   active_id,
  output logic [3:0]   done
);

  // state  | meaning
  // S_IDLE | nothing requested, display blanked, num_out held
  // S_SHOW | source r_cur on screen, counting the dwell
  // S_GAP  | blank interval before pending winner r_pend is re-arbitrated
  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = (GAP > 0) ? CW'(GAP - 1) : '0;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_cur, w_cur_nxt;
  logic [1:0]    r_pend, w_pend_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    w_pick_cur, w_pick_pend;
  logic          w_show_end;
  logic [3:0]    w_grant_nxt;
  logic          w_pwr_nxt;
  logic [31:0]   w_num_nxt;
  logic [1:0]    w_aid_nxt;

  // First set request searching from s upward (mod 4); {found, index}.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] s);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = s + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_pick_cur  = pick(req, r_cur + 2'd1);
  assign w_pick_pend = pick(req, r_pend);
  assign w_show_end  = (r_cnt == DWELL_LAST) || !req[r_cur];

  // State, pointers, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cur     <= 2'd3;
      r_pend    <= 2'd0;
      r_cnt     <= '0;
      grant     <= 4'b0;
      power_on  <= 1'b0;
      num_out   <= 32'b0;
      active_id <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur     <= w_cur_nxt;
      r_pend    <= w_pend_nxt;
      r_cnt     <= w_cnt_nxt;
      grant     <= w_grant_nxt;
      power_on  <= w_pwr_nxt;
      num_out   <= w_num_nxt;
      active_id <= w_aid_nxt;
    end
  end

  // Next-state: arbitration at dwell end and gap end; counter cleared on every entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt + CW'(1);
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_pick_cur[2]) begin
          w_state_nxt = S_SHOW;
          w_cur_nxt   = w_pick_cur[1:0];
        end
      end
      S_SHOW: begin
        if (w_show_end) begin
          w_cnt_nxt = '0;
          if (!w_pick_cur[2]) begin
            w_state_nxt = S_IDLE;
          end else if (w_pick_cur[1:0] == r_cur || GAP == 0) begin
            w_cur_nxt = w_pick_cur[1:0];
          end else begin
            w_state_nxt = S_GAP;
            w_pend_nxt  = w_pick_cur[1:0];
          end
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          if (w_pick_pend[2]) begin
            w_state_nxt = S_SHOW;
            w_cur_nxt   = w_pick_pend[1:0];
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: registered values follow the next state so grant and data appear together;
  // done is decoded from the current dwell count and the live request.
  always_comb begin
    w_grant_nxt = 4'b0;
    w_pwr_nxt   = 1'b0;
    w_num_nxt   = num_out;
    w_aid_nxt   = active_id;
    done        = 4'b0;
    if (w_state_nxt == S_SHOW) begin
      w_grant_nxt = 4'b1 << w_cur_nxt;
      w_pwr_nxt   = 1'b1;
      w_num_nxt   = data_in[{w_cur_nxt, 5'b0} +: 32];
      w_aid_nxt   = w_cur_nxt;
    end
    if (r_state == S_SHOW && r_cnt == DWELL_LAST && req[r_cur]) done[r_cur] = 1'b1;
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: a cycle model pushes expected outputs into a
// scoreboard queue as each stimulus cycle is driven; each test pops and compares.
module tb_display_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] data_in;
  logic [31:0]  u0_num, u1_num;
  logic         u0_pwr, u1_pwr;
  logic [3:0]   u0_grant, u1_grant, u0_done, u1_done;
  logic [1:0]   u0_aid, u1_aid;

  logic         sel;
  logic [31:0]  o_num;
  logic         o_pwr;
  logic [3:0]   o_grant;
  logic [1:0]   o_aid;
  logic [3:0]   obs_done;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  grant;
    logic        pwr;
    logic [31:0] num;
    logic [1:0]  aid;
    logic [3:0]  done;
  } exp_t;
  exp_t sb_q[$];

  // model state
  int         m_state;   // 0 idle, 1 show, 2 gap
  logic [1:0] m_cur, m_pend, m_aid;
  int         m_cnt;
  logic [31:0] m_num;
  int         mdw, mgp;

  always #5 clk = ~clk;

  display_scheduler #(.DWELL(4), .GAP(2), .CW(8)) u0 (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .num_out(u0_num), .power_on(u0_pwr), .grant(u0_grant),
    .active_id(u0_aid), .done(u0_done));

  display_scheduler #(.DWELL(4), .GAP(0), .CW(8)) u1 (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .num_out(u1_num), .power_on(u1_pwr), .grant(u1_grant),
    .active_id(u1_aid), .done(u1_done));

  assign o_num   = sel ? u1_num   : u0_num;
  assign o_pwr   = sel ? u1_pwr   : u0_pwr;
  assign o_grant = sel ? u1_grant : u0_grant;
  assign o_aid   = sel ? u1_aid   : u0_aid;

  function automatic logic [1:0] pickm(input logic [3:0] r, input logic [1:0] s);
    logic [1:0] idx;
    for (int k = 0; k < 4; k++) begin
      idx = s + 2'(k);
      if (r[idx]) return idx;
    end
    return s;
  endfunction

  // Drive one cycle of stimulus, capture pre-edge done, advance the model, push expectation.
  task automatic drive(input logic [3:0] r, input logic rst);
    exp_t e;
    logic [1:0] w;
    req = r;
    reset = rst;
    #1;
    obs_done = sel ? u1_done : u0_done;
    mdw = 4;
    mgp = sel ? 0 : 2;
    e.done = 4'b0;
    if (m_state == 1 && m_cnt == mdw - 1 && r[m_cur]) e.done[m_cur] = 1'b1;
    if (rst) begin
      m_state = 0; m_cur = 2'd3; m_pend = 2'd0; m_cnt = 0; m_num = 32'b0; m_aid = 2'd0;
    end else begin
      case (m_state)
        0: if (r != 4'b0) begin
             m_cur = pickm(r, m_cur + 2'd1); m_state = 1; m_cnt = 0;
           end
        1: if (m_cnt == mdw - 1 || !r[m_cur]) begin
             if (r == 4'b0) m_state = 0;
             else begin
               w = pickm(r, m_cur + 2'd1);
               if (w != m_cur && mgp > 0) begin m_state = 2; m_pend = w; end
               else m_cur = w;
             end
             m_cnt = 0;
           end else m_cnt++;
        default: if (m_cnt == mgp - 1) begin
             if (r == 4'b0) m_state = 0;
             else begin m_cur = pickm(r, m_pend); m_state = 1; end
             m_cnt = 0;
           end else m_cnt++;
      endcase
      if (m_state == 1) begin
        m_num = data_in[int'(m_cur) * 32 +: 32];
        m_aid = m_cur;
      end
    end
    e.grant = (m_state == 1) ? (4'b1 << m_cur) : 4'b0;
    e.pwr   = (m_state == 1);
    e.num   = m_num;
    e.aid   = m_aid;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    sel = 1'b0;
    data_in = '0;
    drive(4'b0, 1'b1);
    void'(sb_q.pop_front());
    drive(4'b0, 1'b1);
    e = sb_q.pop_front();
    checks++;
    if ({o_grant, o_pwr, o_num, o_aid} !== 39'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {o_grant, o_pwr, o_num, o_aid});
    end
    checks++;
    if ({u0_done, u1_done, u1_grant, u1_pwr} !== 13'b0) begin
      failures++;
      $display("FAIL reset_done got=%h exp=0", {u0_done, u1_done, u1_grant, u1_pwr});
    end
    checks++;
    if ({o_grant, o_pwr, o_num, o_aid, obs_done} !== {e.grant, e.pwr, e.num, e.aid, e.done}) begin
      failures++;
      $display("FAIL reset_sb got=%h exp=%h", {o_grant, o_pwr, o_num, o_aid, obs_done}, e);
    end
  endtask

  task automatic test_single();
    exp_t e;
    int dones = 0;
    int drops = 0;
    sel = 1'b0;
    data_in = {96'b0, 32'h12345678};
    drive(4'b0, 1'b1);
    void'(sb_q.pop_front());
    for (int i = 1; i <= 14; i++) begin
      if (i == 12) data_in[31:0] = 32'h9ABCDEF0;
      drive(4'b0001, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if ({o_grant, o_pwr, o_num, o_aid, obs_done} !== {e.grant, e.pwr, e.num, e.aid, e.done}) begin
        failures++;
        $display("FAIL single step=%0d got=%h exp=%h", i, {o_grant, o_pwr, o_num, o_aid, obs_done}, e);
      end
      if (obs_done == 4'b0001) dones++;
      if (o_grant !== 4'b0001 || o_pwr !== 1'b1) drops++;
    end
    checks++;
    if (dones != 3) begin
      failures++;
      $display("FAIL single_done_count got=%0d exp=3", dones);
    end
    checks++;
    if (drops != 0) begin
      failures++;
      $display("FAIL single_grant_drops got=%0d exp=0", drops);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [3:0] prev;
    int order[$];
    int exp_order[4] = '{0, 1, 3, 0};
    sel = 1'b0;
    data_in = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    drive(4'b0, 1'b1);
    void'(sb_q.pop_front());
    prev = 4'b0;
    for (int i = 1; i <= 24; i++) begin
      drive(4'b1011, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if ({o_grant, o_pwr, o_num, o_aid, obs_done} !== {e.grant, e.pwr, e.num, e.aid, e.done}) begin
        failures++;
        $display("FAIL rr step=%0d got=%h exp=%h", i, {o_grant, o_pwr, o_num, o_aid, obs_done}, e);
      end
      if (prev == 4'b0 && o_grant != 4'b0) order.push_back(int'(o_aid));
      prev = o_grant;
    end
    checks++;
    if (order.size() != 4) begin
      failures++;
      $display("FAIL rr_grant_count got=%0d exp=4", order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (order[k] != exp_order[k]) begin
          failures++;
          $display("FAIL rr_order idx=%0d got=%0d exp=%0d", k, order[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    logic [3:0] r;
    int dones = 0;
    int blanks = 0;
    sel = 1'b0;
    data_in = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    for (int i = 0; i <= 5; i++) begin
      r = (i == 0) ? 4'b0 : ((i < 3) ? 4'b0100 : 4'b0001);
      drive(r, i == 0);
      e = sb_q.pop_front();
      checks++;
      if ({o_grant, o_pwr, o_num, o_aid, obs_done} !== {e.grant, e.pwr, e.num, e.aid, e.done}) begin
        failures++;
        $display("FAIL abort step=%0d got=%h exp=%h", i, {o_grant, o_pwr, o_num, o_aid, obs_done}, e);
      end
      if (i > 0 && obs_done != 4'b0) dones++;
      if (i >= 3 && i <= 4 && o_pwr == 1'b0 && o_grant == 4'b0) blanks++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abort_done got=%0d exp=0", dones);
    end
    checks++;
    if (blanks != 2) begin
      failures++;
      $display("FAIL abort_gap got=%0d exp=2", blanks);
    end
    checks++;
    if (o_grant !== 4'b0001 || o_num !== 32'hAAAA0000) begin
      failures++;
      $display("FAIL abort_next got=%h/%h exp=1/aaaa0000", o_grant, o_num);
    end
  endtask

  task automatic test_pending_withdraw();
    exp_t e;
    logic [3:0] r;
    sel = 1'b0;
    data_in = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    for (int i = 0; i <= 7; i++) begin
      r = (i == 0) ? 4'b0 : ((i <= 5) ? 4'b0011 : 4'b1000);
      drive(r, i == 0);
      e = sb_q.pop_front();
      checks++;
      if ({o_grant, o_pwr, o_num, o_aid, obs_done} !== {e.grant, e.pwr, e.num, e.aid, e.done}) begin
        failures++;
        $display("FAIL pend step=%0d got=%h exp=%h", i, {o_grant, o_pwr, o_num, o_aid, obs_done}, e);
      end
    end
    checks++;
    if (o_grant !== 4'b1000 || o_aid !== 2'd3 || o_num !== 32'hDDDD0003) begin
      failures++;
      $display("FAIL pend_winner got=%h/%0d/%h exp=8/3/dddd0003", o_grant, o_aid, o_num);
    end
  endtask

  task automatic test_reset_mid_show();
    exp_t e;
    sel = 1'b0;
    data_in = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    for (int i = 0; i <= 10; i++) begin
      drive((i == 0) ? 4'b0 : 4'b0011, (i == 0) || (i == 9));
      e = sb_q.pop_front();
      checks++;
      if ({o_grant, o_pwr, o_num, o_aid, obs_done} !== {e.grant, e.pwr, e.num, e.aid, e.done}) begin
        failures++;
        $display("FAIL rstmid step=%0d got=%h exp=%h", i, {o_grant, o_pwr, o_num, o_aid, obs_done}, e);
      end
      if (i == 7) begin
        checks++;
        if (o_grant !== 4'b0010) begin
          failures++;
          $display("FAIL rstmid_src1 got=%h exp=2", o_grant);
        end
      end
      if (i == 9) begin
        checks++;
        if ({o_grant, o_pwr, o_num, o_aid, u0_done} !== 43'b0) begin
          failures++;
          $display("FAIL rstmid_clear got=%h exp=0", {o_grant, o_pwr, o_num, o_aid, u0_done});
        end
      end
    end
    checks++;
    if (o_grant !== 4'b0001 || o_num !== 32'hAAAA0000) begin
      failures++;
      $display("FAIL rstmid_first got=%h/%h exp=1/aaaa0000", o_grant, o_num);
    end
  endtask

  task automatic test_gap0();
    exp_t e;
    int lows = 0;
    int switch_seen = 0;
    logic after_done;
    sel = 1'b1;
    data_in = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    drive(4'b0, 1'b1);
    void'(sb_q.pop_front());
    for (int i = 1; i <= 10; i++) begin
      drive(4'b0101, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if ({o_grant, o_pwr, o_num, o_aid, obs_done} !== {e.grant, e.pwr, e.num, e.aid, e.done}) begin
        failures++;
        $display("FAIL gap0 step=%0d got=%h exp=%h", i, {o_grant, o_pwr, o_num, o_aid, obs_done}, e);
      end
      after_done = (obs_done == 4'b0001);
      if (o_pwr !== 1'b1) lows++;
      if (after_done && switch_seen == 0) begin
        switch_seen = 1;
        checks++;
        if (o_grant !== 4'b0100 || o_num !== 32'hCCCC0002) begin
          failures++;
          $display("FAIL gap0_switch got=%h/%h exp=4/cccc0002", o_grant, o_num);
        end
      end
    end
    checks++;
    if (lows != 0 || switch_seen != 1) begin
      failures++;
      $display("FAIL gap0_direct low_cycles=%0d switches=%0d exp=0/1", lows, switch_seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    reset = 1'b1;
    req = 4'b0;
    data_in = '0;
    obs_done = 4'b0;
    m_state = 0; m_cur = 2'd3; m_pend = 2'd0; m_cnt = 0; m_num = 32'b0; m_aid = 2'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_pending_withdraw();
    test_reset_mid_show();
    test_gap0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
